fe_frombytes_stream: RTL
========================

# fe_frombytes_stream

Byte-serial decoder from the 32-byte little-endian encoding of a GF(2^255-19) element to the 10-limb radix-2^25.5 form used by the field arithmetic. It does the inverse of the limb-to-byte path that feeds the zero check and the byte-equality compare. It sits on the signature and public-key input path: bytes arrive one per cycle over a valid/ready stream, and a 320-bit limb vector is presented over a second valid/ready handshake.

## Interface
- No parameters. Element size is fixed at 32 bytes, 10 limbs and 32 bits per limb slot.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `in_valid` in 1: `in_byte` is valid.
- `in_ready` out 1: block accepts a byte this cycle.
- `in_byte` in 8: encoding byte; byte s[0] (least significant) first, s[31] last.
- `out_valid` out 1: `f_out` / `noncanon` are valid.
- `out_ready` in 1: consumer accepts the output this cycle.
- `f_out` out 320: limb i in bits [32i+31:32i], zero-extended.
- `noncanon` out 1: encoding is non-canonical. Tied 0 unless the configuration macro is defined.

## Operation
- States:
  - LOAD: `in_ready`=1.
  - CONV: both ready and valid are 0.
  - HOLD: `out_valid`=1.
- LOAD:
  - A byte is accepted on a cycle with `in_valid`&&`in_ready`.
  - It is written to buffer byte index `cnt` (5-bit counter), and `cnt` increments.
  - Acceptance at `cnt`=31 wraps `cnt` to 0 and moves the FSM to CONV.
- CONV: one cycle. Limbs are registered from buffer bits b[254:0]. Bit 255 is ignored for the value.
  - h0=b[25:0], h1=b[50:26], h2=b[76:51], h3=b[101:77], h4=b[127:102]
  - h5=b[152:128], h6=b[178:153], h7=b[203:179], h8=b[229:204], h9=b[254:230]
  - Even limbs are 26 bits and odd limbs are 25 bits. Upper bits of each 32-bit slot are 0.
  - No modular reduction is performed. Values in [p, 2^255) pass through unchanged.
  - The FSM moves to HOLD.
- HOLD:
  - `f_out` and `noncanon` are stable.
  - On `out_valid`&&`out_ready` the FSM moves to LOAD.
  - `in_ready` rises the cycle after the handshake. A byte presented during HOLD is not consumed.
- No overlap between frames: minimum 34 cycles per element with both sides always ready.
- Input stalls (`in_valid`=0) inside a frame are allowed for any length. `cnt` and buffer hold their values.
- Output back-pressure is allowed for any length. HOLD persists and the outputs do not change.

## Timing
- Reset values:
  - state=LOAD, `cnt`=0, `in_ready`=1 (first cycle after reset deasserts)
  - `out_valid`=0, `f_out`=0, `noncanon`=0, buffer=0
- Latency: 32nd byte accepted at edge N → CONV during cycle N..N+1 → `out_valid`=1 after edge N+1.
- `in_ready` is a registered state decode with no combinational path from `out_ready`.
- `rst` asserted mid-frame or in HOLD aborts the frame:
  - Partial bytes are discarded and `cnt`=0.
  - `out_valid` drops after the reset edge.
  - No output is produced for the aborted frame.
- `rst` has priority over any simultaneous handshake.

## Configuration
- Macro `FE_FROMBYTES_CANON_CHK_EN`.
- Defined: CONV also registers `noncanon` = s[31][7] | (b[254:8] all ones && s[0] >= 8'hED), i.e. encoded value ≥ 2^255-19 or top bit set. `noncanon` is valid with `out_valid`.
- Undefined: comparison logic is absent and `noncanon` is constant 0.
- `f_out` and the timing are identical in both builds.

## Test plan
- All-zero bytes, `out_ready`=1:
  - `f_out`=0 and `noncanon`=0.
  - `out_valid` rises 2 edges after the 32nd byte, lasts 1 cycle, and `in_ready` returns the next cycle.
- s[0]=8'h01, rest 0 → limb0=1, others 0. Then s[3]=8'h04, rest 0 (bit 26) → limb1=1, others 0.
- All bytes 8'hFF:
  - Limbs alternate 32'h03FFFFFF / 32'h01FFFFFF, with limb9=32'h01FFFFFF.
  - `noncanon`=1 with macro, 0 without.
- p encoding: s[0]=8'hED, s[1..30]=8'hFF, s[31]=8'h7F.
  - limb0=32'h03FFFFED, limbs 1-9 at maximum width.
  - `noncanon`=1 with macro.
  - Same frame with s[0]=8'hEC → `noncanon`=0.
- Random `in_valid` gaps plus `out_ready` held low 10 cycles:
  - `f_out` is stable through HOLD.
  - A byte offered during HOLD is not consumed.
  - Next frame decodes correctly.
- `rst` pulsed after 17 bytes, then a full fresh frame → output reflects only the fresh 32 bytes.

Source files
------------

// File: rtl/fe_frombytes_stream_if.sv
// Byte-in / limb-vector-out stream bundle for fe_frombytes_stream.
// slave: the decoder side; master: the producer/consumer driving it.
interface fe_frombytes_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_byte;
  logic         out_valid;
  logic         out_ready;
  logic [319:0] f_out;
  logic         noncanon;

  modport slave (
    input  in_valid, in_byte, out_ready,
    output in_ready, out_valid, f_out, noncanon
  );

  modport master (
    output in_valid, in_byte, out_ready,
    input  in_ready, out_valid, f_out, noncanon
  );
endinterface

// File: rtl/fe_frombytes_stream.sv
// Byte-serial decoder: 32-byte little-endian field element -> 10 radix-2^25.5 limbs.
// Optional macro FE_FROMBYTES_CANON_CHK_EN adds the non-canonical-encoding flag.
module fe_frombytes_stream (
  input  logic                  clk,
  input  logic                  rst,
  fe_frombytes_stream_if.slave  bus
);

`ifdef FE_FROMBYTES_CANON_CHK_EN
  localparam int BUF_W = 256;
`else
  // Bit 255 never affects the value, so it is not stored when nothing inspects it.
  localparam int BUF_W = 255;
`endif

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_CONV = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic [319:0]       f_q, f_d;

  function automatic logic [319:0] unpack_limbs(input logic [254:0] b);
    logic [319:0] f;
    f[ 31:  0] = {6'd0, b[ 25:  0]};
    f[ 63: 32] = {7'd0, b[ 50: 26]};
    f[ 95: 64] = {6'd0, b[ 76: 51]};
    f[127: 96] = {7'd0, b[101: 77]};
    f[159:128] = {6'd0, b[127:102]};
    f[191:160] = {7'd0, b[152:128]};
    f[223:192] = {6'd0, b[178:153]};
    f[255:224] = {7'd0, b[203:179]};
    f[287:256] = {6'd0, b[229:204]};
    f[319:288] = {7'd0, b[254:230]};
    return f;
  endfunction

`ifdef FE_FROMBYTES_CANON_CHK_EN
  logic nc_q, nc_d;

  // Value >= 2^255-19 means bits 254..8 all set and low byte >= 0xED.
  function automatic logic canon_chk(input logic [255:0] b);
    return b[255] | ((&b[254:8]) & (b[7:0] >= 8'hED));
  endfunction
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    f_d     = f_q;
`ifdef FE_FROMBYTES_CANON_CHK_EN
    nc_d    = nc_q;
`endif
    case (state_q)
      ST_LOAD: begin
        if (bus.in_valid) begin
          if (cnt_q == 5'd31) begin
            buf_d[BUF_W-1:248] = bus.in_byte[BUF_W-249:0];
            state_d            = ST_CONV;
          end else begin
            buf_d[{cnt_q, 3'b000} +: 8] = bus.in_byte;
          end
          cnt_d = cnt_q + 5'd1;
        end
      end
      ST_CONV: begin
        f_d     = unpack_limbs(buf_q[254:0]);
`ifdef FE_FROMBYTES_CANON_CHK_EN
        nc_d    = canon_chk(buf_q);
`endif
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (bus.out_ready) state_d = ST_LOAD;
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      cnt_q   <= '0;
      buf_q   <= '0;
      f_q     <= '0;
`ifdef FE_FROMBYTES_CANON_CHK_EN
      nc_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
      f_q     <= f_d;
`ifdef FE_FROMBYTES_CANON_CHK_EN
      nc_q    <= nc_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == ST_LOAD);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.f_out     = f_q;
`ifdef FE_FROMBYTES_CANON_CHK_EN
  assign bus.noncanon  = nc_q;
`else
  assign bus.noncanon  = 1'b0;
`endif

endmodule
